// File: rtl/memarb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package memarb_pkg;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } memarb_src_e;

    localparam int MEMARB_AW = 16;
    localparam int MEMARB_DW = 16;

endpackage

// File: rtl/memarb_tag_fifo.sv
// Source-tag FIFO: remembers which requester issued each outstanding read so
// in-order responses can be steered back. Depth is a parameter, data is 1 bit.
import memarb_pkg::*;

module memarb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  memarb_src_e            din,
    output memarb_src_e            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Wrap modulo depth so non-power-of-two depths also behave.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = memarb_src_e'(tag_q[rd_ptr_q]);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            tag_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-source memory port arbiter (fetch vs load/store) with in-order read
// response routing. Define MEMARB_RR_EN for 1-bit round-robin instead of
// fixed load/store priority with the fetch starvation override.
import memarb_pkg::*;

module mem_port_arbiter #(
    parameter int AW         = MEMARB_AW,
    parameter int DW         = MEMARB_DW,
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_rd,
    input  logic          ls_wr,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rdy,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          rsp_err
);

    localparam int CW = $clog2(MAX_OUTST) + 1;

    logic          full_s, empty_s;
    logic [CW-1:0] count_s;
    memarb_src_e   head_s, din_s;
    logic          push_s, pop_s;
    logic          if_elig_s, ls_elig_s;
    logic          sel_if_s, sel_ls_s;
    logic          rsp_err_q, rsp_err_d;

    // Reset is folded in so every output is quiet while reset is held.
    assign if_elig_s = reset & if_req & ~full_s;
    assign ls_elig_s = reset & (ls_wr | (ls_rd & ~full_s));

`ifdef MEMARB_RR_EN
    memarb_src_e last_q, last_d;

    // Round-robin pick: the source granted last loses a tie.
    always_comb begin
        sel_if_s = 1'b0;
        sel_ls_s = 1'b0;
        if (if_elig_s && ls_elig_s) begin
            if (last_q == SRC_IF) begin
                sel_ls_s = 1'b1;
            end else begin
                sel_if_s = 1'b1;
            end
        end else if (ls_elig_s) begin
            sel_ls_s = 1'b1;
        end else if (if_elig_s) begin
            sel_if_s = 1'b1;
        end else begin
            sel_ls_s = 1'b0;
        end
    end

    // Pointer moves only when a grant actually happens.
    always_comb begin
        last_d = last_q;
        if (if_gnt) begin
            last_d = SRC_IF;
        end else if (ls_gnt) begin
            last_d = SRC_LS;
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin pointer register; starts as "fetch last" so ls wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= SRC_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    // Fixed ls priority, overridden once fetch has waited STARVE_MAX ls grants.
    always_comb begin
        sel_if_s = 1'b0;
        sel_ls_s = 1'b0;
        if (if_elig_s && (starve_q == STARVE_LIM)) begin
            sel_if_s = 1'b1;
        end else if (ls_elig_s) begin
            sel_ls_s = 1'b1;
        end else if (if_elig_s) begin
            sel_if_s = 1'b1;
        end else begin
            sel_ls_s = 1'b0;
        end
    end

    // Count ls grants that bypass a waiting fetch, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign mem_req = sel_if_s | sel_ls_s;
    assign if_gnt  = sel_if_s & mem_rdy;
    assign ls_gnt  = sel_ls_s & mem_rdy;

    // Request payload mux; a read-and-write ls request goes out as a write.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sel_ls_s) begin
            mem_we    = ls_wr;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (sel_if_s) begin
            mem_we    = 1'b0;
            mem_addr  = if_addr;
            mem_wdata = '0;
        end else begin
            mem_we    = 1'b0;
        end
    end

    assign push_s = if_gnt | (ls_gnt & ~ls_wr);
    assign din_s  = ls_gnt ? SRC_LS : SRC_IF;
    assign pop_s  = mem_rvalid & ~empty_s;

    memarb_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign if_rvalid = pop_s & (head_s == SRC_IF);
    assign ls_rvalid = pop_s & (head_s == SRC_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;
    assign busy      = (count_s != '0);

    assign rsp_err_d = rsp_err_q | (mem_rvalid & empty_s);

    // Sticky flag for a response with no matching outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;

endmodule
